// File: rtl/vga_sync_generator_if.sv
// Signal bundle between the horizontal pixel counter, the VGA sync generator
// and the renderer/game logic that consume the timing outputs.
interface vga_sync_generator_if;
    logic        v_enable;
    logic [15:0] h_count;
    logic [15:0] v_count;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        frame_start;
    logic [15:0] frame_count;

    // Upstream counter and downstream consumers view the bundle as master
    modport master (
        output v_enable, h_count,
        input  v_count, hsync, vsync, video_on, pixel_x, pixel_y,
               frame_start, frame_count
    );

    // The sync generator itself
    modport slave (
        input  v_enable, h_count,
        output v_count, hsync, vsync, video_on, pixel_x, pixel_y,
               frame_start, frame_count
    );
endinterface

// File: rtl/vga_sync_generator.sv
// VGA sync generator: keeps the vertical line counter, decodes registered
// hsync/vsync/video_on, visible pixel coordinates, a frame-start strobe and a
// frame counter from the free-running h_count and the v_enable line pulse.
module vga_sync_generator #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic                  clk_25MHz,
    input  logic                  rst_n,
    vga_sync_generator_if.slave   bus
);

    // Region bounds in 16-bit unsigned arithmetic, all derived from the timing parameters
    localparam logic [15:0] H_VIS        = 16'(H_VISIBLE);
    localparam logic [15:0] H_TOTAL      = 16'(H_VISIBLE + H_FP + H_SYNC + H_BP);
    localparam logic [15:0] H_SYNC_START = 16'(H_VISIBLE + H_FP);
    localparam logic [15:0] H_SYNC_END   = 16'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [15:0] V_VIS        = 16'(V_VISIBLE);
    localparam logic [15:0] V_LAST       = 16'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [15:0] V_SYNC_START = 16'(V_VISIBLE + V_FP);
    localparam logic [15:0] V_SYNC_END   = 16'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [15:0] row_next;
    logic [15:0] row_eff;
    logic        h_in_range;
    logic        hsync_d;
    logic        vsync_d;
    logic        video_on_d;
    logic [9:0]  pixel_x_d;
    logic [9:0]  pixel_y_d;
    logic        frame_start_d;

    // Effective row: v_count lags one cycle at line start, so use its next value while v_enable is high
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        row_next = (bus.v_count == V_LAST) ? 16'd0 : bus.v_count + 16'd1;
        row_eff  = bus.v_count;
        if (bus.v_enable) begin
            row_eff = row_next;
        end
    end

    // Decode the current (h_count, row_eff) position; out-of-range h_count reads as blanking
    always_comb begin
        h_in_range    = (bus.h_count < H_TOTAL);
        hsync_d       = 1'b1;
        vsync_d       = 1'b1;
        video_on_d    = 1'b0;
        pixel_x_d     = '0;
        pixel_y_d     = '0;
        frame_start_d = 1'b0;
        if (h_in_range && bus.h_count >= H_SYNC_START && bus.h_count <= H_SYNC_END) begin
            hsync_d = 1'b0;
        end
        if (row_eff >= V_SYNC_START && row_eff <= V_SYNC_END) begin
            vsync_d = 1'b0;
        end
        if (h_in_range && bus.h_count < H_VIS && row_eff < V_VIS) begin
            video_on_d = 1'b1;
            pixel_x_d  = bus.h_count[9:0];
            pixel_y_d  = row_eff[9:0];
        end
        if (h_in_range && bus.h_count == 16'd0 && row_eff == 16'd0) begin
            frame_start_d = 1'b1;
        end
    end

    // Line counter: advances on every v_enable pulse, wraps after the last line, holds otherwise
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            bus.v_count <= '0;
        end else if (bus.v_enable) begin
            bus.v_count <= row_next;
        end
    end

    // Output registers: one cycle behind the decoded position; frame_count follows frame_start by one edge
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            bus.hsync       <= 1'b1;
            bus.vsync       <= 1'b1;
            bus.video_on    <= 1'b0;
            bus.pixel_x     <= '0;
            bus.pixel_y     <= '0;
            bus.frame_start <= 1'b0;
            bus.frame_count <= '0;
        end else begin
            bus.hsync       <= hsync_d;
            bus.vsync       <= vsync_d;
            bus.video_on    <= video_on_d;
            bus.pixel_x     <= pixel_x_d;
            bus.pixel_y     <= pixel_y_d;
            bus.frame_start <= frame_start_d;
            bus.frame_count <= bus.frame_count + {15'd0, bus.frame_start};
        end
    end

endmodule

// File: tb/tb_vga_sync_generator.sv
// Scoreboard bench for vga_sync_generator: the driver pushes the expected
// registered outputs for every applied vector, the monitor pops and compares
// one entry per clock. Frames are walked with a reduced set of h_count
// sample points per line to stay within a small cycle budget.
module tb_vga_sync_generator;

    typedef struct packed {
        logic [15:0] v_count;
        logic        hsync;
        logic        vsync;
        logic        video_on;
        logic [9:0]  pixel_x;
        logic [9:0]  pixel_y;
        logic        frame_start;
        logic [15:0] frame_count;
    } obs_t;

    typedef struct {
        obs_t  o;
        string tag;
    } sb_entry_t;

    logic clk_25MHz = 1'b0;
    logic rst_n;

    vga_sync_generator_if bus ();

    vga_sync_generator u_dut (
        .clk_25MHz (clk_25MHz),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    sb_entry_t sb_q[$];
    int        n_vec = 0;
    int        n_bad = 0;
    string     cur_tag = "init";

    // Model state: line counter, last registered frame_start, frame counter
    logic [15:0] m_vc = '0;
    logic        m_fs = 1'b0;
    logic [15:0] m_fc = '0;

    // Per-phase tallies of what the monitor observed
    int cnt_video = 0;
    int cnt_hs_low = 0;
    int cnt_vs_low = 0;
    int cnt_fs = 0;

    // h_count sample points per compressed line (includes an out-of-range value)
    int h_list [12] = '{0, 1, 2, 638, 639, 640, 655, 656, 751, 752, 799, 900};

    function automatic obs_t reset_obs();
        obs_t r;
        r.v_count     = 16'd0;
        r.hsync       = 1'b1;
        r.vsync       = 1'b1;
        r.video_on    = 1'b0;
        r.pixel_x     = 10'd0;
        r.pixel_y     = 10'd0;
        r.frame_start = 1'b0;
        r.frame_count = 16'd0;
        return r;
    endfunction

    function automatic obs_t sample();
        obs_t s;
        s.v_count     = bus.v_count;
        s.hsync       = bus.hsync;
        s.vsync       = bus.vsync;
        s.video_on    = bus.video_on;
        s.pixel_x     = bus.pixel_x;
        s.pixel_y     = bus.pixel_y;
        s.frame_start = bus.frame_start;
        s.frame_count = bus.frame_count;
        return s;
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got vc=%0d hs=%b vs=%b vo=%b px=%0d py=%0d fs=%b fc=%0d, want vc=%0d hs=%b vs=%b vo=%b px=%0d py=%0d fs=%b fc=%0d",
                     name, act.v_count, act.hsync, act.vsync, act.video_on, act.pixel_x,
                     act.pixel_y, act.frame_start, act.frame_count,
                     exp.v_count, exp.hsync, exp.vsync, exp.video_on, exp.pixel_x,
                     exp.pixel_y, exp.frame_start, exp.frame_count);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Apply one vector at the falling edge and queue the outputs expected after the next rising edge
    task automatic drive(input logic [15:0] h, input logic ve, input logic rst);
        obs_t        e;
        logic [15:0] row;
        sb_entry_t   ent;
        @(negedge clk_25MHz);
        rst_n        = rst;
        bus.h_count  = h;
        bus.v_enable = ve;
        if (!rst) begin
            m_vc = '0;
            m_fs = 1'b0;
            m_fc = '0;
            e    = reset_obs();
        end else begin
            row           = ve ? ((m_vc == 16'd524) ? 16'd0 : m_vc + 16'd1) : m_vc;
            e.v_count     = row;
            e.hsync       = !(h >= 16'd656 && h <= 16'd751);
            e.vsync       = !(row == 16'd490 || row == 16'd491);
            e.video_on    = (h < 16'd640) && (row < 16'd480);
            e.pixel_x     = e.video_on ? h[9:0] : 10'd0;
            e.pixel_y     = e.video_on ? row[9:0] : 10'd0;
            e.frame_start = (h == 16'd0) && (row == 16'd0);
            e.frame_count = m_fc + {15'd0, m_fs};
            m_vc = row;
            m_fs = e.frame_start;
            m_fc = e.frame_count;
        end
        ent.o   = e;
        ent.tag = cur_tag;
        sb_q.push_back(ent);
    endtask

    // One compressed line starting at sample index 'start'; index 0 carries the v_enable pulse
    task automatic row_from(input int start);
        for (int i = start; i < 12; i++) begin
            drive(16'(h_list[i]), (i == 0), 1'b1);
        end
    endtask

    // Let the last queued vector be registered and compared
    task automatic sync();
        @(posedge clk_25MHz);
        #2;
    endtask

    task automatic clear_counts();
        cnt_video  = 0;
        cnt_hs_low = 0;
        cnt_vs_low = 0;
        cnt_fs     = 0;
    endtask

    // Monitor: one expected entry per clock, compared just after the rising edge
    sb_entry_t mon_ent;
    obs_t      mon_act;
    always @(posedge clk_25MHz) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_ent = sb_q.pop_front();
            mon_act = sample();
            check_obs(mon_ent.tag, mon_act, mon_ent.o);
            if (mon_act.video_on)    cnt_video++;
            if (!mon_act.hsync)      cnt_hs_low++;
            if (!mon_act.vsync)      cnt_vs_low++;
            if (mon_act.frame_start) cnt_fs++;
        end
    end

    // Watchdog: the run is a fixed-length stimulus list, so any overrun is a hang
    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b1;
        bus.h_count  = 16'd100;
        bus.v_enable = 1'b0;
        #2;
        rst_n = 1'b0;

        // Reset held for 5 cycles with h_count moving and one v_enable pulse
        cur_tag = "reset_hold";
        drive(16'd100, 1'b0, 1'b0);
        drive(16'd101, 1'b0, 1'b0);
        drive(16'd0,   1'b1, 1'b0);
        drive(16'd799, 1'b0, 1'b0);
        drive(16'd656, 1'b0, 1'b0);
        sync();

        // Release at h_count=0 then sweep the whole of row 0
        clear_counts();
        cur_tag = "hsweep_row0";
        for (int h = 0; h < 800; h++) begin
            drive(16'(h), 1'b0, 1'b1);
        end
        sync();
        check_val("hsweep_video_cycles", cnt_video, 640);
        check_val("hsweep_hsync_low_cycles", cnt_hs_low, 96);
        check_val("hsweep_frame_start_count", cnt_fs, 1);
        check_val("hsweep_frame_count", bus.frame_count, 1);

        // Line wrap: pixel_y at the first pixel of the new line shows the new row
        cur_tag = "line_wrap";
        drive(16'd0, 1'b1, 1'b1);
        sync();
        check_val("wrap_v_count", bus.v_count, 1);
        check_val("wrap_pixel_y", bus.pixel_y, 1);
        check_val("wrap_video_on", bus.video_on, 1);
        row_from(1);

        // Walk to the end of the frame (rows 2..524)
        cur_tag = "rows_to_end";
        for (int r = 0; r < 523; r++) row_from(0);
        sync();
        check_val("end_v_count", bus.v_count, 524);

        // One full compressed frame, rows 0..524
        clear_counts();
        cur_tag = "full_frame";
        for (int r = 0; r < 525; r++) row_from(0);
        sync();
        check_val("frame_vsync_low_cycles", cnt_vs_low, 24);
        check_val("frame_video_cycles", cnt_video, 2400);
        check_val("frame_hsync_low_cycles", cnt_hs_low, 1050);
        check_val("frame_start_once", cnt_fs, 1);
        check_val("frame_count_after_frame", bus.frame_count, 2);

        // Frame counter wrap: preload 65535, then the next frame_start rolls it to 0
        cur_tag = "fc_wrap";
        m_fc = 16'hFFFF;
        drive(16'd900, 1'b0, 1'b1);
        force bus.frame_count = 16'hFFFF;
        @(posedge clk_25MHz);
        #3;
        release bus.frame_count;
        drive(16'd0, 1'b1, 1'b1);
        drive(16'd1, 1'b0, 1'b1);
        sync();
        check_val("frame_count_wrap", bus.frame_count, 0);
        row_from(2);

        // Advance to row 200, h_count 300
        cur_tag = "to_row200";
        for (int r = 0; r < 199; r++) row_from(0);
        drive(16'd0, 1'b1, 1'b1);
        for (int h = 1; h <= 300; h++) drive(16'(h), 1'b0, 1'b1);
        sync();
        check_val("row200_v_count", bus.v_count, 200);

        // Mid-line reset: outputs go to reset values without waiting for a clock edge
        cur_tag = "midline_reset";
        drive(16'd301, 1'b0, 1'b0);
        #1;
        check_obs("async_reset_immediate", sample(), reset_obs());
        drive(16'd302, 1'b0, 1'b0);
        drive(16'd303, 1'b0, 1'b1);
        drive(16'd900, 1'b0, 1'b1);
        sync();
        check_val("out_of_range_video_on", bus.video_on, 0);
        check_val("out_of_range_hsync", bus.hsync, 1);
        check_val("after_reset_v_count", bus.v_count, 0);
        for (int h = 304; h < 800; h++) drive(16'(h), 1'b0, 1'b1);

        // Next v_enable moves to row 1; no frame_start until the frame wraps
        clear_counts();
        cur_tag = "post_reset_frame";
        drive(16'd0, 1'b1, 1'b1);
        sync();
        check_val("post_reset_row1", bus.v_count, 1);
        row_from(1);
        for (int r = 0; r < 523; r++) row_from(0);
        sync();
        check_val("post_reset_no_frame_start", cnt_fs, 0);
        check_val("post_reset_v_count_524", bus.v_count, 524);
        clear_counts();
        row_from(0);
        sync();
        check_val("post_reset_first_frame_start", cnt_fs, 1);
        check_val("post_reset_frame_count", bus.frame_count, 1);

        check_val("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_generator.md
# vga_sync_generator

Downstream stage of the free-running horizontal pixel counter in the 640x480@60 Hz VGA path. It consumes `h_count` and the one-cycle `v_enable` line pulse and maintains the vertical line counter. From the two counts it produces registered active-low `hsync`/`vsync`, the `video_on` blanking flag, visible pixel coordinates, a frame-start strobe and a frame counter. The pixel renderer and the game logic consume these outputs.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch (H_TOTAL = 800)
- V_VISIBLE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch (V_TOTAL = 525)

Ports:
- clk_25MHz  in  1  pixel clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- v_enable  in  1  high for exactly the cycle in which h_count == 0 following an 799->0 wrap
- h_count  in  16  current horizontal position, 0..799
- v_count  out  16  registered line counter, 0..524
- hsync  out  1  registered, active-low
- vsync  out  1  registered, active-low
- video_on  out  1  registered, high in visible region
- pixel_x  out  10  registered visible column, 0..639, 0 when blanked
- pixel_y  out  10  registered visible row, 0..479, 0 when blanked
- frame_start  out  1  registered one-cycle strobe at pixel (0,0)
- frame_count  out  16  registered frame counter, wraps 65535->0

## Operation
- Line counter: on each edge with v_enable=1, `v_count` advances by one. It wraps from V_TOTAL-1 (524) to 0. Otherwise it holds.
- Effective row: row_eff is computed combinationally and compensates for `v_count` lagging by one cycle at line start.
  - When v_enable=1, row_eff is the next value of `v_count`, i.e. (`v_count`==524 ? 0 : `v_count`+1).
  - Otherwise row_eff = `v_count`.
- Decode uses `h_count` and row_eff. Each decoded value is registered once.
  - hsync = 0 iff 656 <= h_count <= 751
  - vsync = 0 iff 490 <= row_eff <= 491
  - video_on = 1 iff h_count < 640 and row_eff < 480
  - pixel_x = h_count[9:0] when video_on, else 0
  - pixel_y = row_eff[9:0] when video_on, else 0
  - frame_start = 1 iff h_count == 0 and row_eff == 0
- frame_count increments on the edge that registers frame_start=1.
- Out-of-range input (h_count > 799) is treated as blanking: video_on=0, hsync=1, no frame_start. `v_count` is unaffected.
- All comparisons are unsigned and use 16-bit arithmetic. Region bounds are derived from the parameters, not hard-coded.

## Timing
- Reset values (asynchronous on rst_n=0, held while low): v_count=0, hsync=1, vsync=1, video_on=0, pixel_x=0, pixel_y=0, frame_start=0, frame_count=0.
- Latency: every decoded output is exactly 1 cycle behind the h_count/row_eff it describes. hsync, vsync, video_on and the pixel coordinates stay mutually aligned.
- The upstream counter has no reset, so reset of this block may occur mid-line.
  - After release, row 0 is assumed for the remainder of the current line.
  - The next v_enable moves to row 1.
  - The first frame_start after a mid-frame reset therefore occurs one full frame later.
  - Release of reset exactly at h_count==0 with v_enable=0 (power-up) produces frame_start on the next cycle.
- Simultaneous v_enable=1 with v_count=524 selects row_eff=0. This produces frame_start and wraps v_count to 0 on the same edge.
- A v_enable pulse at any h_count other than 0 is still honoured (v_count advances). There is no error flag.

## Test plan
- Reset: hold rst_n=0 for 5 cycles while driving h_count -> all outputs at reset values. After release with h_count=0 and v_enable=0 -> frame_start=1 one cycle later and frame_count=1 one cycle after that.
- Horizontal decode, row 0: sweep h_count 0..799.
  - video_on high for 640 cycles, delayed 1 cycle.
  - hsync low for exactly 96 cycles, registered from h_count 656..751.
  - pixel_x tracks h_count-1 per cycle, 0..639.
- Line wrap: drive v_enable with h_count=0 -> v_count increments on that edge. pixel_y at that pixel (one cycle later) equals the new row, not the old row.
- Full frame: run 525x800 cycles driven by a model of the upstream counter.
  - vsync low for exactly 2x800 cycles (rows 490-491).
  - video_on high for 480x640 cycles.
  - v_count wraps 524->0 with frame_start=1 exactly once per frame.
  - frame_count +1 per frame.
- Frame counter wrap: preload by running 65536 frames, or force frame_count=65535 -> next frame_start yields frame_count=0.
- Mid-line reset: assert rst_n=0 at h_count=300 of row 200 -> outputs reset immediately. After release, v_count=0, and v_count=1 at the next v_enable. The first frame_start appears 525 lines later. Also drive h_count=900 -> video_on=0 and hsync=1.
